// File: rtl/player_shot_ctrl.sv
// Player shot controller: launches a shot from the paddle centre on a fire edge,
// moves it up once per frame, scores alien hits and enforces a cooldown between shots.
module player_shot_ctrl #(
   parameter int BULLET_W        = 4,
   parameter int BULLET_H        = 12,
   parameter int SHOT_SPEED      = 8,
   parameter int COOLDOWN_FRAMES = 10
) (
   input  logic               pixel_clk,
   input  logic               rst,
   input  logic               fsync,
   input  logic signed [11:0] hpos,
   input  logic signed [11:0] vpos,
   input  logic               fire_btn,
   input  logic signed [11:0] paddle_left,
   input  logic signed [11:0] paddle_right,
   input  logic signed [11:0] paddle_top,
   input  logic               alien_hit,
   output logic               bullet_active,
   output logic signed [11:0] bullet_left,
   output logic signed [11:0] bullet_right,
   output logic signed [11:0] bullet_top,
   output logic signed [11:0] bullet_bottom,
   output logic [7:0]         pixel [0:2],
   output logic               active,
   output logic [7:0]         hits_total
);

   typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

   // A cooldown of zero frames still waits for one fsync before re-arming.
   localparam int CD_LIMIT = (COOLDOWN_FRAMES < 1) ? 1 : COOLDOWN_FRAMES;
   localparam logic [15:0]        CD_LAST = 16'(CD_LIMIT - 1);
   localparam logic signed [11:0] HALF_W  = 12'(BULLET_W / 2);
   localparam logic signed [11:0] W_M1    = 12'(BULLET_W - 1);
   localparam logic signed [11:0] H_FULL  = 12'(BULLET_H);
   localparam logic signed [11:0] SPEED   = 12'(SHOT_SPEED);

   state_t             state, state_n;
   logic               fire_q, fire_rise;
   logic               pending, pending_n;
   logic [15:0]        cd_count, cd_count_n;
   logic signed [11:0] left_n, right_n, top_n, bottom_n;
   logic [7:0]         hits_n;
   logic signed [11:0] paddle_sum, paddle_mid, launch_left, top_moved;

   assign fire_rise   = fire_btn & ~fire_q;
   assign paddle_sum  = paddle_left + paddle_right;
   assign paddle_mid  = paddle_sum >>> 1;
   assign launch_left = paddle_mid - HALF_W;
   assign top_moved   = bullet_top - SPEED;

   always_comb begin
      state_n    = state;
      pending_n  = pending;
      cd_count_n = cd_count;
      left_n     = bullet_left;
      right_n    = bullet_right;
      top_n      = bullet_top;
      bottom_n   = bullet_bottom;
      hits_n     = hits_total;
      case (state)
         IDLE: begin
            if (fsync && (pending || fire_rise)) begin
               state_n   = FLYING;
               pending_n = 1'b0;
               left_n    = launch_left;
               right_n   = launch_left + W_M1;
               top_n     = paddle_top - H_FULL;
               bottom_n  = paddle_top - 12'sd1;
            end else if (fire_rise) begin
               pending_n = 1'b1;
            end
         end
         FLYING: begin
            pending_n = 1'b0;
            // A hit takes precedence over the frame move in the same cycle.
            if (alien_hit) begin
               state_n    = COOLDOWN;
               cd_count_n = '0;
               if (hits_total != 8'hFF) hits_n = hits_total + 8'd1;
            end else if (fsync) begin
               if (top_moved < 12'sd0) begin
                  state_n    = COOLDOWN;
                  cd_count_n = '0;
               end else begin
                  top_n    = top_moved;
                  bottom_n = bullet_bottom - SPEED;
               end
            end
         end
         COOLDOWN: begin
            pending_n = 1'b0;
            if (fsync) begin
               if (cd_count == CD_LAST) state_n = IDLE;
               else cd_count_n = cd_count + 16'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         state         <= IDLE;
         fire_q        <= 1'b0;
         pending       <= 1'b0;
         cd_count      <= '0;
         bullet_active <= 1'b0;
         bullet_left   <= '0;
         bullet_right  <= '0;
         bullet_top    <= '0;
         bullet_bottom <= '0;
         hits_total    <= '0;
      end else begin
         state         <= state_n;
         fire_q        <= fire_btn;
         pending       <= pending_n;
         cd_count      <= cd_count_n;
         bullet_active <= (state_n == FLYING);
         bullet_left   <= left_n;
         bullet_right  <= right_n;
         bullet_top    <= top_n;
         bullet_bottom <= bottom_n;
         hits_total    <= hits_n;
      end
   end

   assign active = bullet_active
                   && (hpos >= bullet_left) && (hpos <= bullet_right)
                   && (vpos >= bullet_top)  && (vpos <= bullet_bottom);

   always_comb begin
      pixel[0] = 8'h00;
      pixel[1] = active ? 8'hFF : 8'h00;
      pixel[2] = active ? 8'hFF : 8'h00;
   end

endmodule

// File: tb/tb_player_shot_ctrl.sv
// Self-checking bench for player_shot_ctrl: directed scenarios plus randomized
// stimulus compared against a frame-level behavioural model of the shot.
module tb_player_shot_ctrl;

   localparam int BW  = 4;
   localparam int BH  = 12;
   localparam int SPD = 8;
   localparam int CDF = 10;

   logic               pixel_clk = 1'b0;
   logic               rst, fsync, fire_btn, alien_hit;
   logic signed [11:0] hpos, vpos, paddle_left, paddle_right, paddle_top;
   logic               bullet_active, active;
   logic signed [11:0] bullet_left, bullet_right, bullet_top, bullet_bottom;
   logic [7:0]         pixel [0:2];
   logic [7:0]         hits_total;

   int checks = 0;
   int passed = 0;

   // Model: flying flag, frames left before re-arming, latched request, score.
   bit                 m_flying, m_pending, m_prev;
   int                 m_cool_left, m_hits;
   logic signed [11:0] m_left, m_right, m_top, m_bottom;

   always #5 pixel_clk = ~pixel_clk;

   player_shot_ctrl #(.BULLET_W(BW), .BULLET_H(BH), .SHOT_SPEED(SPD), .COOLDOWN_FRAMES(CDF)) dut (
      .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .hpos(hpos), .vpos(vpos),
      .fire_btn(fire_btn), .paddle_left(paddle_left), .paddle_right(paddle_right),
      .paddle_top(paddle_top), .alien_hit(alien_hit), .bullet_active(bullet_active),
      .bullet_left(bullet_left), .bullet_right(bullet_right), .bullet_top(bullet_top),
      .bullet_bottom(bullet_bottom), .pixel(pixel), .active(active), .hits_total(hits_total)
   );

   function automatic bit exp_active();
      return m_flying && (hpos >= m_left) && (hpos <= m_right)
             && (vpos >= m_top) && (vpos <= m_bottom);
   endfunction

   // One clock: advance the model with the inputs seen at this edge, then settle.
   task automatic tick();
      bit                 rise;
      logic signed [11:0] sum, mid, t;
      @(posedge pixel_clk);
      if (rst) begin
         m_flying = 0; m_pending = 0; m_prev = 0; m_cool_left = 0; m_hits = 0;
         m_left = '0; m_right = '0; m_top = '0; m_bottom = '0;
      end else begin
         rise = fire_btn && !m_prev;
         if (m_flying) begin
            m_pending = 0;
            if (alien_hit) begin
               m_flying = 0;
               m_cool_left = (CDF < 1) ? 1 : CDF;
               if (m_hits < 255) m_hits++;
            end else if (fsync) begin
               t = m_top - 12'(SPD);
               if (t < 0) begin
                  m_flying = 0;
                  m_cool_left = (CDF < 1) ? 1 : CDF;
               end else begin
                  m_top = t;
                  m_bottom = m_bottom - 12'(SPD);
               end
            end
         end else if (m_cool_left > 0) begin
            m_pending = 0;
            if (fsync) m_cool_left--;
         end else if (fsync && (m_pending || rise)) begin
            sum = paddle_left + paddle_right;
            mid = sum >>> 1;
            m_left = mid - 12'(BW / 2);
            m_right = m_left + 12'(BW - 1);
            m_top = paddle_top - 12'(BH);
            m_bottom = paddle_top - 12'sd1;
            m_flying = 1;
            m_pending = 0;
         end else if (rise) begin
            m_pending = 1;
         end
         m_prev = fire_btn;
      end
      #1;
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         fsync = 1'b1; tick();
         fsync = 1'b0; tick();
      end
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      rst = 1'b1; fsync = 1'b1; fire_btn = 1'b1; alien_hit = 1'b1;
      tick();
      fsync = 1'b0; fire_btn = 1'b0; alien_hit = 1'b0;
      tick();
      rst = 1'b0;
      checks++; if (bullet_active !== 1'b0) $display("[TB] FAIL reset_active: got %0b expected 0", bullet_active); else passed++;
      checks++; if ({bullet_left, bullet_right, bullet_top, bullet_bottom} !== 48'h0)
         $display("[TB] FAIL reset_bounds: got %0d %0d %0d %0d expected 0 0 0 0", bullet_left, bullet_right, bullet_top, bullet_bottom);
      else passed++;
      checks++; if (hits_total !== 8'd0) $display("[TB] FAIL reset_hits: got %0d expected 0", hits_total); else passed++;
      checks++; if ({active, pixel[2], pixel[1], pixel[0]} !== 25'h0)
         $display("[TB] FAIL reset_pixel: got %0b %h%h%h expected 0 000000", active, pixel[2], pixel[1], pixel[0]);
      else passed++;
   endtask

   task automatic test_launch();
      $display("[TB] test_launch");
      paddle_left = 12'sd300; paddle_right = 12'sd340; paddle_top = 12'sd440;
      fire_btn = 1'b1; tick();
      fire_btn = 1'b0; tick();
      checks++; if (bullet_active !== 1'b0) $display("[TB] FAIL launch_wait: got %0b expected 0", bullet_active); else passed++;
      fsync = 1'b1; tick();
      fsync = 1'b0;
      checks++; if (bullet_active !== 1'b1) $display("[TB] FAIL launch_active: got %0b expected 1", bullet_active); else passed++;
      checks++; if (bullet_left !== 12'sd318 || bullet_right !== 12'sd321 || bullet_top !== 12'sd428 || bullet_bottom !== 12'sd439)
         $display("[TB] FAIL launch_bounds: got %0d %0d %0d %0d expected 318 321 428 439", bullet_left, bullet_right, bullet_top, bullet_bottom);
      else passed++;
   endtask

   task automatic test_flight_miss();
      $display("[TB] test_flight_miss");
      frames(5);
      checks++; if (bullet_top !== 12'sd388 || bullet_bottom !== 12'sd399 || bullet_left !== 12'sd318)
         $display("[TB] FAIL flight_move: got top %0d bottom %0d left %0d expected 388 399 318", bullet_top, bullet_bottom, bullet_left);
      else passed++;
      frames(48);
      hpos = 12'sd319; vpos = 12'sd10;
      tick();
      checks++; if (bullet_top !== 12'sd4 || active !== 1'b1 || pixel[2] !== 8'hFF || pixel[0] !== 8'h00)
         $display("[TB] FAIL flight_top4: got top %0d active %0b pix %h%h%h expected 4 1 FFFF00", bullet_top, active, pixel[2], pixel[1], pixel[0]);
      else passed++;
      fsync = 1'b1; tick();
      fsync = 1'b0;
      checks++; if (bullet_active !== 1'b0 || active !== 1'b0)
         $display("[TB] FAIL miss_end: got bullet_active %0b active %0b expected 0 0", bullet_active, active);
      else passed++;
      checks++; if (bullet_top !== 12'sd4 || bullet_bottom !== 12'sd15)
         $display("[TB] FAIL miss_hold: got top %0d bottom %0d expected 4 15", bullet_top, bullet_bottom);
      else passed++;
      frames(9);
      fire_btn = 1'b1; tick();
      fire_btn = 1'b0; tick();
      fsync = 1'b1; tick();
      fsync = 1'b0;
      checks++; if (bullet_active !== 1'b0) $display("[TB] FAIL cooldown_drop: got %0b expected 0", bullet_active); else passed++;
      fire_btn = 1'b1; fsync = 1'b1; tick();
      fire_btn = 1'b0; fsync = 1'b0;
      checks++; if (bullet_active !== 1'b1) $display("[TB] FAIL cooldown_len: got %0b expected 1", bullet_active); else passed++;
   endtask

   task automatic test_hit();
      $display("[TB] test_hit");
      alien_hit = 1'b1; fsync = 1'b1; tick();
      alien_hit = 1'b0; fsync = 1'b0;
      checks++; if (bullet_active !== 1'b0 || bullet_top !== 12'sd428 || hits_total !== 8'd1)
         $display("[TB] FAIL hit_fsync: got active %0b top %0d hits %0d expected 0 428 1", bullet_active, bullet_top, hits_total);
      else passed++;
      alien_hit = 1'b1; tick();
      alien_hit = 1'b0;
      checks++; if (hits_total !== 8'd1) $display("[TB] FAIL hit_ignored: got %0d expected 1", hits_total); else passed++;
      for (int i = 2; i <= 256; i++) begin
         frames(CDF);
         fire_btn = 1'b1; fsync = 1'b1; tick();
         fire_btn = 1'b0; fsync = 1'b0; tick();
         alien_hit = 1'b1; tick();
         alien_hit = 1'b0;
         if (i == 200) begin
            checks++; if (hits_total !== 8'd200) $display("[TB] FAIL hit_count: got %0d expected 200", hits_total); else passed++;
         end
      end
      checks++; if (hits_total !== 8'd255) $display("[TB] FAIL hit_saturate: got %0d expected 255", hits_total); else passed++;
   endtask

   task automatic test_held_button();
      $display("[TB] test_held_button");
      frames(CDF);
      fire_btn = 1'b1; fsync = 1'b1; tick();
      fsync = 1'b0; tick();
      fire_btn = 1'b0; tick();
      fire_btn = 1'b1; tick();
      alien_hit = 1'b1; tick();
      alien_hit = 1'b0;
      checks++; if (hits_total !== 8'd255) $display("[TB] FAIL held_saturate: got %0d expected 255", hits_total); else passed++;
      frames(CDF + 3);
      checks++; if (bullet_active !== 1'b0) $display("[TB] FAIL held_no_launch: got %0b expected 0", bullet_active); else passed++;
      fire_btn = 1'b0; tick();
      fire_btn = 1'b1; tick();
      fsync = 1'b1; tick();
      fsync = 1'b0; fire_btn = 1'b0;
      checks++; if (bullet_active !== 1'b1) $display("[TB] FAIL held_new_edge: got %0b expected 1", bullet_active); else passed++;
   endtask

   task automatic test_reset_mid_flight();
      $display("[TB] test_reset_mid_flight");
      hpos = 12'sd0; vpos = 12'sd0;
      rst = 1'b1; alien_hit = 1'b1; fsync = 1'b1; tick();
      rst = 1'b0; alien_hit = 1'b0; fsync = 1'b0;
      checks++; if (hits_total !== 8'd0 || bullet_active !== 1'b0)
         $display("[TB] FAIL rst_flight: got hits %0d active %0b expected 0 0", hits_total, bullet_active);
      else passed++;
      checks++; if ({bullet_left, bullet_right, bullet_top, bullet_bottom} !== 48'h0 || active !== 1'b0 || pixel[1] !== 8'h00)
         $display("[TB] FAIL rst_bounds: got %0d %0d %0d %0d active %0b expected all 0", bullet_left, bullet_right, bullet_top, bullet_bottom, active);
      else passed++;
   endtask

   task automatic test_raster();
      int lit;
      logic [24:0] want;
      $display("[TB] test_raster");
      paddle_left = 12'sd100; paddle_right = 12'sd139; paddle_top = 12'sd300;
      fire_btn = 1'b1; fsync = 1'b1; tick();
      fire_btn = 1'b0; fsync = 1'b0;
      lit = 0;
      for (int y = -3; y < BH + 3; y++) begin
         for (int x = -3; x < BW + 3; x++) begin
            hpos = m_left + 12'(x);
            vpos = m_top + 12'(y);
            tick();
            want = exp_active() ? {1'b1, 24'hFFFF00} : 25'h0;
            checks++; if ({active, pixel[2], pixel[1], pixel[0]} !== want)
               $display("[TB] FAIL raster_px(%0d,%0d): got %0b %h%h%h expected %h", hpos, vpos, active, pixel[2], pixel[1], pixel[0], want);
            else passed++;
            if (active === 1'b1) lit++;
         end
      end
      checks++; if (lit !== BW * BH) $display("[TB] FAIL raster_count: got %0d expected %0d", lit, BW * BH); else passed++;
   endtask

   task automatic test_random();
      $display("[TB] test_random");
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 499) == 0);
         fsync = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) fire_btn = ~fire_btn;
         alien_hit = ($urandom_range(0, 40) == 0);
         paddle_left = 12'($urandom_range(0, 600));
         paddle_right = paddle_left + 12'($urandom_range(10, 60));
         paddle_top = 12'($urandom_range(20, 470));
         hpos = m_left + 12'($urandom_range(0, 7)) - 12'sd2;
         vpos = m_top + 12'($urandom_range(0, 17)) - 12'sd2;
         tick();
         checks++; if (bullet_active !== m_flying) $display("[TB] FAIL rnd_active@%0d: got %0b expected %0b", i, bullet_active, m_flying); else passed++;
         checks++; if (bullet_left !== m_left || bullet_right !== m_right || bullet_top !== m_top || bullet_bottom !== m_bottom)
            $display("[TB] FAIL rnd_bounds@%0d: got %0d %0d %0d %0d expected %0d %0d %0d %0d", i,
                     bullet_left, bullet_right, bullet_top, bullet_bottom, m_left, m_right, m_top, m_bottom);
         else passed++;
         checks++; if (hits_total !== 8'(m_hits)) $display("[TB] FAIL rnd_hits@%0d: got %0d expected %0d", i, hits_total, m_hits); else passed++;
         checks++; if (active !== exp_active() || pixel[2] !== (exp_active() ? 8'hFF : 8'h00))
            $display("[TB] FAIL rnd_raster@%0d: got %0b %h expected %0b", i, active, pixel[2], exp_active());
         else passed++;
      end
      rst = 1'b0; fsync = 1'b0; alien_hit = 1'b0;
   endtask

   initial begin
      rst = 1'b1; fsync = 1'b0; fire_btn = 1'b0; alien_hit = 1'b0;
      hpos = '0; vpos = '0; paddle_left = '0; paddle_right = '0; paddle_top = '0;
      m_flying = 0; m_pending = 0; m_prev = 0; m_cool_left = 0; m_hits = 0;
      m_left = '0; m_right = '0; m_top = '0; m_bottom = '0;
      test_reset();
      test_launch();
      test_flight_miss();
      test_hit();
      test_held_button();
      test_reset_mid_flight();
      test_raster();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
